// File: rtl/msrv32_pkg.sv
// Shared definitions for the MS-RV32I store buffer slice.
// Holds the store funct3 codes, the store-buffer state encoding, the base
// byte-enable masks and the bus payload struct used by the buffer.
package msrv32_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned MASK_W = XLEN / 8;

   // Store size codes (funct3[1:0]); 2'b11 is reserved
   localparam logic [1:0] F3_SB   = 2'b00;
   localparam logic [1:0] F3_SH   = 2'b01;
   localparam logic [1:0] F3_SW   = 2'b10;
   localparam logic [1:0] F3_RSVD = 2'b11;

   // Base byte-enable masks, shifted into place by the byte offset
   localparam logic [MASK_W-1:0] MASK_B   = 4'b0001;
   localparam logic [MASK_W-1:0] MASK_H   = 4'b0011;
   localparam logic [MASK_W-1:0] MASK_ALL = 4'b1111;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PEND = 1'b1
   } sb_state_e;

   // Write payload presented on the data bus
   typedef struct packed {
      logic [XLEN-1:0]   addr;
      logic [XLEN-1:0]   data;
      logic [MASK_W-1:0] mask;
   } store_req_t;

endpackage

// File: rtl/msrv32_store_fmt.sv
// Store formatter: replicates store data across byte lanes, builds the
// byte-enable mask and flags whether the request is aligned and legal.
// Ports:
//   funct3    - store size (SB/SH/SW, 2'b11 reserved)
//   addr_lo   - effective address bits [1:0]
//   rs2       - raw store data
//   data_c    - lane-replicated write data
//   mask_c    - byte enables
//   aligned_c - 1 when size/offset combination is legal (0 for reserved)
module msrv32_store_fmt
   import msrv32_pkg::*;
(
   input  logic [1:0]        funct3,
   input  logic [1:0]        addr_lo,
   input  logic [XLEN-1:0]   rs2,
   output logic [XLEN-1:0]   data_c,
   output logic [MASK_W-1:0] mask_c,
   output logic              aligned_c
);

   // Size decode; reserved code falls through to the not-aligned default
   always_comb begin
      data_c    = rs2;
      mask_c    = '0;
      aligned_c = 1'b0;
      case (funct3)
         F3_SB: begin
            data_c    = {4{rs2[7:0]}};
            mask_c    = MASK_W'(MASK_B << addr_lo);
            aligned_c = 1'b1;
         end
         F3_SH: begin
            data_c    = {2{rs2[15:0]}};
            mask_c    = MASK_W'(MASK_H << {addr_lo[1], 1'b0});
            aligned_c = ~addr_lo[0];
         end
         F3_SW: begin
            data_c    = rs2;
            mask_c    = MASK_ALL;
            aligned_c = (addr_lo == 2'b00);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/msrv32_store_buffer.sv
// Single-entry store buffer between execute and the data-memory write port.
// Accepts an aligned store, holds it on the bus until dmwr_ready_in, and
// stalls the pipeline only when another memory access arrives mid-drain.
// Optional feature macro: MSRV32_STORE_CNT_EN adds store_cnt_out, a
// wrapping count of completed write handshakes.
// Ports:
//   ms_riscv32_mp_clk_in / ms_riscv32_mp_rst_in - clock, async active-low reset
//   mem_wr_req_in, mem_rd_req_in                 - store / load present
//   funct3_in, iadder_in, rs2_in                 - store size, address, data
//   trap_taken_in                                - blocks acceptance
//   dmwr_ready_in                                - bus accepts the write
//   dmwr_req_out, d_addr_out, data_out, wr_mask_out - registered write bus
//   stall_out                                    - combinational pipeline hold
//   store_cnt_out                                - completed-store count (macro)
module msrv32_store_buffer
   import msrv32_pkg::*;
(
   input  logic              ms_riscv32_mp_clk_in,
   input  logic              ms_riscv32_mp_rst_in,
   input  logic              mem_wr_req_in,
   input  logic              mem_rd_req_in,
   input  logic [1:0]        funct3_in,
   input  logic [XLEN-1:0]   iadder_in,
   input  logic [XLEN-1:0]   rs2_in,
   input  logic              trap_taken_in,
   input  logic              dmwr_ready_in,
   output logic              dmwr_req_out,
   output logic [XLEN-1:0]   d_addr_out,
   output logic [XLEN-1:0]   data_out,
   output logic [MASK_W-1:0] wr_mask_out,
   output logic              stall_out
`ifdef MSRV32_STORE_CNT_EN
   ,output logic [XLEN-1:0]  store_cnt_out
`endif
);

   sb_state_e  state, state_nxt;
   store_req_t bus_q, bus_nxt;
   logic       req_nxt;

   logic [XLEN-1:0]   fmt_data_c;
   logic [MASK_W-1:0] fmt_mask_c;
   logic              fmt_aligned_c;
   logic              accept_c;

   msrv32_store_fmt u_fmt (
      .funct3    (funct3_in),
      .addr_lo   (iadder_in[1:0]),
      .rs2       (rs2_in),
      .data_c    (fmt_data_c),
      .mask_c    (fmt_mask_c),
      .aligned_c (fmt_aligned_c)
   );

   // New entry may load when empty or on the edge the current one drains
   assign accept_c = mem_wr_req_in & ~trap_taken_in & fmt_aligned_c
                   & (funct3_in != F3_RSVD)
                   & ((state == ST_IDLE) | dmwr_ready_in);

   // Stall only while an undrained store blocks another memory access
   assign stall_out = (state == ST_PEND) & ~dmwr_ready_in
                    & (mem_wr_req_in | mem_rd_req_in);

   // Next-state and next bus contents
   always_comb begin
      state_nxt = state;
      bus_nxt   = bus_q;
      req_nxt   = dmwr_req_out;
      case (state)
         ST_IDLE: begin
            if (accept_c) begin
               state_nxt = ST_PEND;
               req_nxt   = 1'b1;
               bus_nxt   = '{addr: {iadder_in[XLEN-1:2], 2'b00},
                             data: fmt_data_c,
                             mask: fmt_mask_c};
            end
         end
         ST_PEND: begin
            if (dmwr_ready_in) begin
               if (accept_c) begin
                  bus_nxt = '{addr: {iadder_in[XLEN-1:2], 2'b00},
                              data: fmt_data_c,
                              mask: fmt_mask_c};
               end else begin
                  state_nxt = ST_IDLE;
                  req_nxt   = 1'b0;
               end
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            req_nxt   = 1'b0;
         end
      endcase
   end

   // State and bus registers; reset discards any buffered entry
   always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
      if (!ms_riscv32_mp_rst_in) begin
         state        <= ST_IDLE;
         bus_q        <= '0;
         dmwr_req_out <= 1'b0;
      end else begin
         state        <= state_nxt;
         bus_q        <= bus_nxt;
         dmwr_req_out <= req_nxt;
      end
   end

   assign d_addr_out  = bus_q.addr;
   assign data_out    = bus_q.data;
   assign wr_mask_out = bus_q.mask;

`ifdef MSRV32_STORE_CNT_EN
   // Completed-handshake counter, wraps naturally at 2^32
   always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
      if (!ms_riscv32_mp_rst_in) begin
         store_cnt_out <= '0;
      end else if (dmwr_req_out & dmwr_ready_in) begin
         store_cnt_out <= store_cnt_out + XLEN'(1);
      end
   end
`endif

endmodule

// File: tb/tb_msrv32_store_buffer.sv
// Directed self-checking bench for msrv32_store_buffer.
module tb_msrv32_store_buffer;

   logic        clk;
   logic        rst_n;
   logic        mem_wr_req;
   logic        mem_rd_req;
   logic [1:0]  funct3;
   logic [31:0] iadder;
   logic [31:0] rs2;
   logic        trap;
   logic        ready;
   logic        req;
   logic [31:0] addr;
   logic [31:0] data;
   logic [3:0]  mask;
   logic        stall;
`ifdef MSRV32_STORE_CNT_EN
   logic [31:0] cnt;
`endif

   int checks;
   int errors;

   msrv32_store_buffer dut (
      .ms_riscv32_mp_clk_in (clk),
      .ms_riscv32_mp_rst_in (rst_n),
      .mem_wr_req_in        (mem_wr_req),
      .mem_rd_req_in        (mem_rd_req),
      .funct3_in            (funct3),
      .iadder_in            (iadder),
      .rs2_in               (rs2),
      .trap_taken_in        (trap),
      .dmwr_ready_in        (ready),
      .dmwr_req_out         (req),
      .d_addr_out           (addr),
      .data_out             (data),
      .wr_mask_out          (mask),
      .stall_out            (stall)
`ifdef MSRV32_STORE_CNT_EN
      ,.store_cnt_out       (cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      mem_wr_req = 1'b0;
      mem_rd_req = 1'b0;
      funct3     = 2'b00;
      iadder     = 32'h0;
      rs2        = 32'h0;
      trap       = 1'b0;
      ready      = 1'b1;
   endtask

   task automatic store(input logic [1:0] f3, input logic [31:0] a, input logic [31:0] d);
      mem_wr_req = 1'b1;
      funct3     = f3;
      iadder     = a;
      rs2        = d;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      #12;
      checks++; if (req !== 1'b0)     begin errors++; $display("FAIL reset_req: got %b want 0", req); end
      checks++; if (addr !== 32'h0)   begin errors++; $display("FAIL reset_addr: got %h want 00000000", addr); end
      checks++; if (data !== 32'h0)   begin errors++; $display("FAIL reset_data: got %h want 00000000", data); end
      checks++; if (mask !== 4'h0)    begin errors++; $display("FAIL reset_mask: got %b want 0000", mask); end
      checks++; if (stall !== 1'b0)   begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
`ifdef MSRV32_STORE_CNT_EN
      checks++; if (cnt !== 32'h0)    begin errors++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
`endif
      cyc();
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_sb();
      store(2'b00, 32'h0000_1003, 32'hAABB_CCDD);
      cyc();
      checks++; if (req !== 1'b1)          begin errors++; $display("FAIL sb_req: got %b want 1", req); end
      checks++; if (addr !== 32'h0000_1000) begin errors++; $display("FAIL sb_addr: got %h want 00001000", addr); end
      checks++; if (data !== 32'hDDDD_DDDD) begin errors++; $display("FAIL sb_data: got %h want dddddddd", data); end
      checks++; if (mask !== 4'b1000)       begin errors++; $display("FAIL sb_mask: got %b want 1000", mask); end
      mem_wr_req = 1'b0;
      cyc();
      checks++; if (req !== 1'b0)          begin errors++; $display("FAIL sb_drain: got %b want 0", req); end
   endtask

   task automatic test_sh();
      store(2'b01, 32'h0000_2002, 32'h0000_1234);
      cyc();
      checks++; if (req !== 1'b1)          begin errors++; $display("FAIL sh_req: got %b want 1", req); end
      checks++; if (addr !== 32'h0000_2000) begin errors++; $display("FAIL sh_addr: got %h want 00002000", addr); end
      checks++; if (data !== 32'h1234_1234) begin errors++; $display("FAIL sh_data: got %h want 12341234", data); end
      checks++; if (mask !== 4'b1100)       begin errors++; $display("FAIL sh_mask: got %b want 1100", mask); end
      mem_wr_req = 1'b0;
      cyc();
      // Byte-0 halfword for the low-lane mask
      store(2'b01, 32'h0000_2000, 32'h0000_5678);
      cyc();
      checks++; if (mask !== 4'b0011)       begin errors++; $display("FAIL sh_mask_lo: got %b want 0011", mask); end
      mem_wr_req = 1'b0;
      cyc();
   endtask

   task automatic test_drop();
      store(2'b01, 32'h0000_2001, 32'h0000_1234);
      cyc();
      checks++; if (req !== 1'b0) begin errors++; $display("FAIL drop_sh_misaligned: got %b want 0", req); end
      store(2'b10, 32'h0000_3002, 32'h1111_2222);
      cyc();
      checks++; if (req !== 1'b0) begin errors++; $display("FAIL drop_sw_misaligned: got %b want 0", req); end
      store(2'b11, 32'h0000_3000, 32'h1111_2222);
      cyc();
      checks++; if (req !== 1'b0) begin errors++; $display("FAIL drop_reserved: got %b want 0", req); end
      mem_wr_req = 1'b0;
      cyc();
   endtask

   task automatic test_stall();
      // No stall in IDLE even with a load present
      mem_rd_req = 1'b1;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_idle: got %b want 0", stall); end
      mem_rd_req = 1'b0;
      ready = 1'b0;
      store(2'b10, 32'h0000_3000, 32'hCAFE_F00D);
      cyc();
      mem_wr_req = 1'b0;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_no_access: got %b want 0", stall); end
      mem_rd_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_cycle%0d: got %b want 1", i, stall); end
         checks++;
         if (req !== 1'b1 || addr !== 32'h0000_3000 || data !== 32'hCAFE_F00D || mask !== 4'b1111) begin
            errors++;
            $display("FAIL stall_hold%0d: got req=%b addr=%h data=%h mask=%b want 1/00003000/cafef00d/1111",
                     i, req, addr, data, mask);
         end
         cyc();
      end
      ready = 1'b1;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_release: got %b want 0", stall); end
      cyc();
      checks++; if (req !== 1'b0) begin errors++; $display("FAIL stall_drain: got %b want 0", req); end
      mem_rd_req = 1'b0;
   endtask

   task automatic test_back_to_back();
      ready = 1'b1;
      store(2'b10, 32'h0000_0010, 32'h0000_0001);
      cyc();
      checks++; if (req !== 1'b1 || addr !== 32'h0000_0010 || data !== 32'h1)
         begin errors++; $display("FAIL b2b_first: got req=%b addr=%h data=%h want 1/00000010/00000001", req, addr, data); end
      store(2'b10, 32'h0000_0014, 32'h0000_0002);
      cyc();
      checks++; if (req !== 1'b1 || addr !== 32'h0000_0014 || data !== 32'h2)
         begin errors++; $display("FAIL b2b_second: got req=%b addr=%h data=%h want 1/00000014/00000002", req, addr, data); end
      mem_wr_req = 1'b0;
      cyc();
      checks++; if (req !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", req); end
   endtask

   task automatic test_trap();
      trap = 1'b1;
      store(2'b10, 32'h0000_0040, 32'h0000_0040);
      cyc();
      checks++; if (req !== 1'b0) begin errors++; $display("FAIL trap_block: got %b want 0", req); end
      trap  = 1'b0;
      ready = 1'b0;
      store(2'b10, 32'h0000_0050, 32'h0000_0050);
      cyc();
      mem_wr_req = 1'b0;
      trap = 1'b1;
      cyc();
      checks++; if (req !== 1'b1 || addr !== 32'h0000_0050)
         begin errors++; $display("FAIL trap_pend_hold: got req=%b addr=%h want 1/00000050", req, addr); end
      trap  = 1'b0;
      ready = 1'b1;
      cyc();
      checks++; if (req !== 1'b0) begin errors++; $display("FAIL trap_pend_drain: got %b want 0", req); end
   endtask

   task automatic test_async_reset();
      ready = 1'b0;
      store(2'b10, 32'h0000_0060, 32'h0000_0060);
      cyc();
      mem_wr_req = 1'b0;
      mem_rd_req = 1'b1;
      #1;
      rst_n = 1'b0;
      #1;
      checks++; if (req !== 1'b0)   begin errors++; $display("FAIL arst_req: got %b want 0", req); end
      checks++; if (addr !== 32'h0) begin errors++; $display("FAIL arst_addr: got %h want 00000000", addr); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL arst_stall: got %b want 0", stall); end
`ifdef MSRV32_STORE_CNT_EN
      checks++; if (cnt !== 32'h0)  begin errors++; $display("FAIL arst_cnt: got %0d want 0", cnt); end
`endif
      idle_inputs();
      cyc();
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_count();
      ready = 1'b1;
      store(2'b10, 32'h0000_0100, 32'hA);
      cyc();
      store(2'b10, 32'h0000_0104, 32'hB);
      cyc();
      store(2'b00, 32'h0000_0109, 32'hC);
      cyc();
      checks++; if (mask !== 4'b0010) begin errors++; $display("FAIL cnt_sb_mask: got %b want 0010", mask); end
      mem_wr_req = 1'b0;
      cyc();
      checks++; if (req !== 1'b0) begin errors++; $display("FAIL cnt_drain: got %b want 0", req); end
`ifdef MSRV32_STORE_CNT_EN
      checks++; if (cnt !== 32'd3) begin errors++; $display("FAIL cnt_three: got %0d want 3", cnt); end
`endif
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_sb();
      test_sh();
      test_drop();
      test_stall();
      test_back_to_back();
      test_trap();
      test_async_reset();
      test_count();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
